// File: rtl/systolic_feeder_2x2_if.sv
// rtl/systolic_feeder_2x2_if.sv - feeder control, operand RAM and array edge-stream bundle
//
// Groups every non-clock/reset signal of the 2x2 systolic operand feeder.
//   master : the feeder (drives control, RAM address/enable and the edge streams)
//   slave  : the environment (drives start and the RAM read data)
// Members:
//   start                      begin one multiply (sampled only when idle)
//   busy, done                 operation status / one-cycle completion pulse
//   mem_en, mem_addr           shared read port to the A and B operand RAMs
//   a_mem_dout, b_mem_dout     RAM read data, one cycle after the address
//   clr_acc                    one-cycle accumulator clear to all PEs
//   out_valid                  edge-stream beat valid
//   a_row0, a_row1             A edge inputs, rows 0 and 1
//   b_col0, b_col1             B edge inputs, columns 0 and 1

interface systolic_feeder_2x2_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic [1:0]        mem_addr;
    logic [DATA_W-1:0] a_mem_dout;
    logic [DATA_W-1:0] b_mem_dout;
    logic              clr_acc;
    logic              out_valid;
    logic [DATA_W-1:0] a_row0;
    logic [DATA_W-1:0] a_row1;
    logic [DATA_W-1:0] b_col0;
    logic [DATA_W-1:0] b_col1;

    modport master (
        input  start,
        input  a_mem_dout,
        input  b_mem_dout,
        output busy,
        output done,
        output mem_en,
        output mem_addr,
        output clr_acc,
        output out_valid,
        output a_row0,
        output a_row1,
        output b_col0,
        output b_col1
    );

    modport slave (
        output start,
        output a_mem_dout,
        output b_mem_dout,
        input  busy,
        input  done,
        input  mem_en,
        input  mem_addr,
        input  clr_acc,
        input  out_valid,
        input  a_row0,
        input  a_row1,
        input  b_col0,
        input  b_col1
    );
endinterface

// File: rtl/systolic_feeder_2x2.sv
// rtl/systolic_feeder_2x2.sv - operand feeder for the 2x2 systolic matrix multiplier
//
// On start, reads the 2x2 A and B matrices (row-major, element (r,c) at address
// 2r+c) from two single-port RAMs sharing one address, clears the array
// accumulators, then streams three skewed beats into the array edges. Row 1 of A
// and column 1 of B lag by one beat to match the diagonal dataflow. After
// DRAIN_CYCLES idle cycles a done pulse marks that the array holds C = A*B.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   systolic_feeder_2x2_if.master (control, RAM read port, edge streams)
// All outputs are decoded from registered state only.

module systolic_feeder_2x2 #(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_feeder_2x2_if.master  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CLEAR  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] LOAD_LAST   = 4'd4;
    localparam logic [3:0] STREAM_LAST = 4'd2;
    localparam logic [3:0] DRAIN_LAST  = 4'(DRAIN_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    // Shared step counter: load index k, stream beat t, or drain cycle.
    logic [3:0]        cnt_q, cnt_d;
    // Operand registers, row-major: [0]=(0,0) [1]=(0,1) [2]=(1,0) [3]=(1,1).
    logic [DATA_W-1:0] a_reg_q [4];
    logic [DATA_W-1:0] b_reg_q [4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    cnt_d   = 4'd0;
                end
            end
            S_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = S_CLEAR;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                cnt_d   = 4'd0;
            end
            S_STREAM: begin
                if (cnt_q == STREAM_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                a_reg_q[i] <= '0;
                b_reg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // RAM data for address k-1 arrives during load step k (1-cycle latency).
            // At k=4 the low bits wrap to 0, so k-1 lands on index 3.
            if (state_q == S_LOAD && cnt_q != 4'd0) begin
                a_reg_q[cnt_q[1:0] - 2'd1] <= bus.a_mem_dout;
                b_reg_q[cnt_q[1:0] - 2'd1] <= bus.b_mem_dout;
            end
        end
    end

    logic load_rd;
    assign load_rd = (state_q == S_LOAD) && (cnt_q < LOAD_LAST);

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.mem_en    = load_rd;
    assign bus.mem_addr  = load_rd ? cnt_q[1:0] : 2'd0;
    assign bus.clr_acc   = (state_q == S_CLEAR);
    assign bus.out_valid = (state_q == S_STREAM);

    // Skewed edge beats: row0/col0 carry index t, row1/col1 carry index t-1;
    // indices outside 0..1 drive zero, as does every non-stream cycle.
    always_comb begin
        bus.a_row0 = '0;
        bus.a_row1 = '0;
        bus.b_col0 = '0;
        bus.b_col1 = '0;
        if (state_q == S_STREAM) begin
            case (cnt_q)
                4'd0: begin
                    bus.a_row0 = a_reg_q[0];
                    bus.b_col0 = b_reg_q[0];
                end
                4'd1: begin
                    bus.a_row0 = a_reg_q[1];
                    bus.a_row1 = a_reg_q[2];
                    bus.b_col0 = b_reg_q[2];
                    bus.b_col1 = b_reg_q[1];
                end
                4'd2: begin
                    bus.a_row1 = a_reg_q[3];
                    bus.b_col1 = b_reg_q[3];
                end
                default: begin
                    bus.a_row0 = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// tb/tb_systolic_feeder_2x2.sv - directed self-checking bench for systolic_feeder_2x2

module tb_systolic_feeder_2x2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_feeder_2x2_if #(.DATA_W(32)) s2 ();
    systolic_feeder_2x2_if #(.DATA_W(32)) s1 ();
    systolic_feeder_2x2_if #(.DATA_W(32)) s15 ();

    systolic_feeder_2x2 #(.DATA_W(32), .DRAIN_CYCLES(2))  dut2  (.clk(clk), .rst(rst), .bus(s2));
    systolic_feeder_2x2 #(.DATA_W(32), .DRAIN_CYCLES(1))  dut1  (.clk(clk), .rst(rst), .bus(s1));
    systolic_feeder_2x2 #(.DATA_W(32), .DRAIN_CYCLES(15)) dut15 (.clk(clk), .rst(rst), .bus(s15));

    logic [31:0] a_mem [4];
    logic [31:0] b_mem [4];

    always @(posedge clk) begin
        if (s2.mem_en)  begin s2.a_mem_dout  <= a_mem[s2.mem_addr];  s2.b_mem_dout  <= b_mem[s2.mem_addr];  end
        if (s1.mem_en)  begin s1.a_mem_dout  <= a_mem[s1.mem_addr];  s1.b_mem_dout  <= b_mem[s1.mem_addr];  end
        if (s15.mem_en) begin s15.a_mem_dout <= a_mem[s15.mem_addr]; s15.b_mem_dout <= b_mem[s15.mem_addr]; end
    end

    // Behavioural 2x2 output-stationary array on dut2: a moves right, b moves down.
    logic [31:0] ra00 = '0, rb00 = '0, ra10 = '0, rb01 = '0;
    logic [31:0] c00 = '0, c01 = '0, c10 = '0, c11 = '0;
    always @(posedge clk) begin
        if (s2.clr_acc) begin
            c00 <= '0; c01 <= '0; c10 <= '0; c11 <= '0;
        end else begin
            c00 <= c00 + s2.a_row0 * s2.b_col0;
            c01 <= c01 + ra00 * s2.b_col1;
            c10 <= c10 + s2.a_row1 * rb00;
            c11 <= c11 + ra10 * rb01;
        end
        ra00 <= s2.a_row0;
        rb00 <= s2.b_col0;
        ra10 <= s2.a_row1;
        rb01 <= s2.b_col1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle trace of dut2, cycle 0 = first cycle after the edge sampling start.
    logic [31:0]  en_m, clr_m, val_m, done_m, busy_m;
    logic [1:0]   addr_t [32];
    logic [127:0] beat_t [32];
    logic [6:0]   ctl_t  [32];

    task automatic capture2(input int ncyc, input int p1, input int p2, input int rcyc);
        @(posedge clk); #1 s2.start = 1'b1;
        @(posedge clk); #1 s2.start = 1'b0;
        en_m = '0; clr_m = '0; val_m = '0; done_m = '0; busy_m = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            en_m[c]   = s2.mem_en;
            clr_m[c]  = s2.clr_acc;
            val_m[c]  = s2.out_valid;
            done_m[c] = s2.done;
            busy_m[c] = s2.busy;
            addr_t[c] = s2.mem_addr;
            beat_t[c] = {s2.a_row0, s2.a_row1, s2.b_col0, s2.b_col1};
            ctl_t[c]  = {s2.busy, s2.done, s2.mem_en, s2.mem_addr, s2.clr_acc, s2.out_valid};
            s2.start  = (c == p1) || (c == p2);
            rst       = (c == rcyc);
        end
        s2.start = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic check_nominal_beats(input string pfx);
        check_eq({pfx, "_beat0"}, beat_t[6], {32'd1, 32'd0, 32'd5, 32'd0});
        check_eq({pfx, "_beat1"}, beat_t[7], {32'd2, 32'd3, 32'd7, 32'd6});
        check_eq({pfx, "_beat2"}, beat_t[8], {32'd0, 32'd4, 32'd0, 32'd8});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d15, nb1, nb15;
        logic [31:0] z1, z15;

        s2.start = 1'b1; s1.start = 1'b0; s15.start = 1'b0;
        a_mem[0] = 32'd1; a_mem[1] = 32'd2; a_mem[2] = 32'd3; a_mem[3] = 32'd4;
        b_mem[0] = 32'd5; b_mem[1] = 32'd6; b_mem[2] = 32'd7; b_mem[3] = 32'd8;

        // Reset held with start high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("reset_outputs", {ctl_t[0][0] & 1'b0, s2.busy, s2.done, s2.mem_en, s2.mem_addr,
                     s2.clr_acc, s2.out_valid, s2.a_row0, s2.a_row1, s2.b_col0, s2.b_col1}, '0);
        end
        @(posedge clk); #1 rst = 1'b0; s2.start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check_eq("idle_after_reset", {s2.busy, s2.mem_en, s2.out_valid}, 3'b000);

        // Nominal run.
        capture2(16, -1, -1, -1);
        for (int c = 0; c < 5; c++)
            check_eq($sformatf("addr_c%0d", c), {en_m[c], addr_t[c]}, (c < 4) ? {1'b1, 2'(c)} : 3'b000);
        check_eq("nom_clr_mask",  clr_m,  32'h0000_0020);
        check_eq("nom_val_mask",  val_m,  32'h0000_01C0);
        check_eq("nom_done_mask", done_m, 32'h0000_0800);
        check_eq("nom_busy_mask", busy_m, 32'h0000_0FFF);
        check_eq("nom_idle_beat", beat_t[9] | beat_t[5] | beat_t[10], '0);
        check_nominal_beats("nom");
        check_eq("c00", c00, 32'd19);
        check_eq("c01", c01, 32'd22);
        check_eq("c10", c10, 32'd43);
        check_eq("c11", c11, 32'd50);

        // start during STREAM (cycle 7) and DONE (cycle 11) is ignored.
        capture2(20, 7, 11, -1);
        check_eq("ign_done_mask", done_m, 32'h0000_0800);
        check_eq("ign_busy_mask", busy_m, 32'h0000_0FFF);

        // Full-width A operands.
        for (int i = 0; i < 4; i++) a_mem[i] = 32'hFFFF_FFFF;
        capture2(16, -1, -1, -1);
        check_eq("ff_beat0", beat_t[6], {32'hFFFF_FFFF, 32'd0, 32'd5, 32'd0});
        check_eq("ff_beat1", beat_t[7], {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd6});
        check_eq("ff_beat2", beat_t[8], {32'd0, 32'hFFFF_FFFF, 32'd0, 32'd8});
        check_eq("ff_busy_mask", busy_m, 32'h0000_0FFF);

        // Reset during LOAD cycle 2 aborts the operation.
        a_mem[0] = 32'd1; a_mem[1] = 32'd2; a_mem[2] = 32'd3; a_mem[3] = 32'd4;
        capture2(20, -1, -1, 2);
        check_eq("abort_ctl_c3",   ctl_t[3], 7'd0);
        check_eq("abort_beat_c3",  beat_t[3], '0);
        check_eq("abort_busy_mask", busy_m, 32'h0000_0007);
        check_eq("abort_no_done",  done_m, 32'h0000_0000);
        capture2(16, -1, -1, -1);
        check_nominal_beats("restart");
        check_eq("restart_done_mask", done_m, 32'h0000_0800);

        // Drain-length extremes.
        @(posedge clk); #1 s1.start = 1'b1; s15.start = 1'b1;
        @(posedge clk); #1 s1.start = 1'b0; s15.start = 1'b0;
        d1 = -1; d15 = -1; nb1 = 0; nb15 = 0; z1 = '0; z15 = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (s1.done && d1 < 0)   d1 = c;
            if (s15.done && d15 < 0) d15 = c;
            if (s1.busy)  nb1++;
            if (s15.busy) nb15++;
            if (c == 9)
                z1 |= s1.a_row0 | s1.a_row1 | s1.b_col0 | s1.b_col1 | {31'd0, s1.out_valid};
            if (c >= 9 && c <= 23)
                z15 |= s15.a_row0 | s15.a_row1 | s15.b_col0 | s15.b_col1 | {31'd0, s15.out_valid};
        end
        check_eq("drain1_done_cycle",  d1,  10);
        check_eq("drain15_done_cycle", d15, 24);
        check_eq("drain1_busy_len",    nb1,  11);
        check_eq("drain15_busy_len",   nb15, 25);
        check_eq("drain1_zero",  z1,  '0);
        check_eq("drain15_zero", z15, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
